// File: rtl/rob_pkg.sv
// Shared ROB types and constants for the Tomasulo core (rob_commit and its neighbours).
// rob_entry_t describes the default-configuration entry layout seen by debug and issue logic.
package rob_pkg;

  localparam int ROB_DEPTH = 8;
  localparam int ROB_TAG_W = $clog2(ROB_DEPTH);
  localparam int XLEN      = 32;
  localparam int RD_W      = 5;

  typedef logic [ROB_TAG_W-1:0] rob_tag_t;

  typedef struct packed {
    logic            valid;
    logic            done;
    logic [RD_W-1:0] rd;
    logic [XLEN-1:0] value;
  } rob_entry_t;

  // x0 is hardwired to zero, so retiring to it must not strobe the register file.
  function automatic logic rd_writes(input logic [RD_W-1:0] rd);
    return rd != '0;
  endfunction

endpackage

// File: rtl/rob_commit.sv
// In-order reorder buffer: allocates at tail, captures CDB results, retires one entry per cycle at head.
// Optional ROB_BYPASS_EN forwards the current-cycle CDB broadcast onto the operand lookup.
module rob_commit #(
  parameter int DEPTH = rob_pkg::ROB_DEPTH,
  parameter int TAG_W = $clog2(DEPTH),
  parameter int XLEN  = rob_pkg::XLEN
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    alloc_valid,
  input  logic [rob_pkg::RD_W-1:0] alloc_rd,
  output logic                    alloc_ready,
  output logic [TAG_W-1:0]        alloc_tag,
  input  logic                    cdb_valid,
  input  logic [TAG_W-1:0]        cdb_tag,
  input  logic [XLEN-1:0]         cdb_data,
  input  logic [TAG_W-1:0]        src_tag,
  output logic                    src_ready,
  output logic [XLEN-1:0]         src_data,
  input  logic                    flush,
  output logic                    reg_write,
  output logic [rob_pkg::RD_W-1:0] write_addr,
  output logic [XLEN-1:0]         write_data,
  output logic [TAG_W:0]          count
);
  import rob_pkg::*;

  localparam int CNT_W = TAG_W + 1;

  // Same layout as rob_entry_t, but with the value width following this instance's XLEN.
  typedef struct packed {
    logic            valid;
    logic            done;
    logic [RD_W-1:0] rd;
    logic [XLEN-1:0] value;
  } entry_t;

  entry_t           ent [DEPTH];
  logic [TAG_W-1:0] head;
  logic [TAG_W-1:0] tail;

  logic alloc_fire;
  logic commit_fire;
  logic cdb_hit;

  assign alloc_ready = (count != CNT_W'(DEPTH));
  assign alloc_tag   = tail;
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign commit_fire = ent[head].valid && ent[head].done;
  assign cdb_hit     = cdb_valid && ent[cdb_tag].valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent[i] <= '0;
      end
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      reg_write  <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent[i].valid <= 1'b0;
        ent[i].done  <= 1'b0;
      end
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      reg_write <= 1'b0;
    end else begin
      if (cdb_hit) begin
        ent[cdb_tag].done  <= 1'b1;
        ent[cdb_tag].value <= cdb_data;
      end

      // Commit clears after the CDB write so a late rebroadcast to head cannot resurrect it.
      if (commit_fire) begin
        ent[head].valid <= 1'b0;
        ent[head].done  <= 1'b0;
        head            <= head + TAG_W'(1);
        write_addr      <= ent[head].rd;
        write_data      <= ent[head].value;
        reg_write       <= rd_writes(ent[head].rd);
      end else begin
        reg_write <= 1'b0;
      end

      // The tail slot is never valid while allocation is possible, so no CDB/commit write collides here.
      if (alloc_fire) begin
        ent[tail].valid <= 1'b1;
        ent[tail].done  <= 1'b0;
        ent[tail].rd    <= alloc_rd;
        ent[tail].value <= '0;
        tail            <= tail + TAG_W'(1);
      end

      case ({alloc_fire, commit_fire})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    src_ready = ent[src_tag].valid && ent[src_tag].done;
    src_data  = src_ready ? ent[src_tag].value : '0;
`ifdef ROB_BYPASS_EN
    if (cdb_valid && (cdb_tag == src_tag) && ent[src_tag].valid) begin
      src_ready = 1'b1;
      src_data  = cdb_data;
    end
`endif
  end

endmodule

// File: doc/rob_commit.md
Name: rob_commit

Overview:
- Reorder buffer for the Tomasulo core.
- Allocates one entry per issued instruction and captures results from the common data bus (CDB).
- Retires entries strictly in program order.
- Sits directly upstream of reg_file: drives its reg_write/write_addr/write_data write port.
- Provides a tag-indexed operand lookup for the issue stage.

Parameters:
- DEPTH, 8, number of entries; power of two, at least 2
- TAG_W, $clog2(DEPTH), width of entry tag / pointer
- XLEN, 32, data width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- alloc_valid  in  1  issue requests an entry
- alloc_rd  in  5  destination register of issued instruction
- alloc_ready  out  1  entry available (count < DEPTH)
- alloc_tag  out  TAG_W  tag given to the request (current tail index)
- cdb_valid  in  1  result broadcast valid
- cdb_tag  in  TAG_W  tag of broadcast result
- cdb_data  in  XLEN  broadcast result
- src_tag  in  TAG_W  operand lookup tag
- src_ready  out  1  looked-up entry is valid and done
- src_data  out  XLEN  looked-up entry value (0 when not ready)
- flush  in  1  synchronous squash of all entries
- reg_write  out  1  commit strobe to reg_file
- write_addr  out  5  committed rd
- write_data  out  XLEN  committed value
- count  out  TAG_W+1  occupied entries

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- While rst=0:
  - all entry valid/done bits clear; head=tail=0; count=0
  - reg_write=0, write_addr=0, write_data=0
- Reset asserted mid-operation discards all in-flight entries immediately.
- Entry state: valid, done, rd[4:0], value[XLEN-1:0]. Head and tail are TAG_W-bit pointers that wrap modulo DEPTH.
- Allocate:
  - alloc_ready = (count != DEPTH). It is combinational from current state, so an entry freed in the same cycle does not raise it.
  - On alloc_valid && alloc_ready at posedge: entry[tail] <= {valid=1, done=0, rd=alloc_rd}; tail++.
  - alloc_tag always equals tail.
- CDB capture:
  - On cdb_valid at posedge, if entry[cdb_tag].valid then done<=1 and value<=cdb_data.
  - A broadcast to an invalid entry is ignored, including the entry being allocated in the same cycle.
  - A second broadcast to an already-done entry overwrites value.
- Commit:
  - If entry[head].valid && entry[head].done at posedge, the entry is cleared and head++.
  - On the same edge, write_addr<=rd and write_data<=value.
  - reg_write<=1 only if rd!=0; it is 0 otherwise (x0 commits retire silently).
  - Otherwise reg_write<=0; write_addr/write_data hold their previous values.
  - Latency: CDB capture at edge N gives earliest commit at edge N+1, with reg_write high for the cycle after edge N+1.
  - At most one retire per cycle.
- Count:
  - count is updated +1 on alloc, -1 on commit, unchanged when both occur.
  - Never exceeds DEPTH.
  - Allocation and commit in the same cycle are legal at any fill level, including full (commit only) and empty (alloc only: the new entry is not done, so no commit).
- Flush (synchronous, highest priority):
  - clears all valid/done bits; head=tail=count=0; reg_write<=0
  - same-cycle alloc, CDB and commit are discarded
- Lookup (combinational):
  - src_ready = entry[src_tag].valid && entry[src_tag].done
  - src_data = src_ready ? value : 0

Optional Feature:
- Macro: ROB_BYPASS_EN
- Defined: the lookup also forwards the current-cycle CDB.
  - If cdb_valid && cdb_tag==src_tag && entry[src_tag].valid, then src_ready=1 and src_data=cdb_data.
  - The CDB takes precedence over the stored value.
- Undefined: the lookup reflects registered state only, so a result becomes visible one cycle after broadcast.

Decomposition:
- Package rob_pkg:
  - ROB_DEPTH, ROB_TAG_W, XLEN constants
  - typedef rob_tag_t
  - typedef struct packed rob_entry_t {valid, done, rd, value}
- No sub-module is needed. Pointer wrap relies on power-of-two DEPTH, so a separate counter module is not justified.

Test Plan:
- Reset and alloc: hold rst=0, then release; alloc rd=1 -> alloc_tag=0, count=1, reg_write=0 with no CDB for 5 cycles.
- In-order commit: alloc rd=1 (tag0) and rd=2 (tag1); CDB tag1=32'h12345678, then tag0=32'hDEADBEEF -> commit x1=DEADBEEF, next cycle x2=12345678; count returns to 0.
- Full boundary: 8 allocs -> alloc_ready=0, count=8, and a 9th alloc_valid is ignored. Complete tag0 -> the cycle after commit shows alloc_ready=1 and the next alloc_tag=0 (wrap).
- x0 commit: alloc rd=0, CDB 32'hFFFFFFFF -> entry retires, count decrements, reg_write stays 0.
- Flush mid-stream: 3 entries with tag1 done, assert flush concurrently with alloc and CDB -> count=0, no reg_write, next alloc_tag=0. Repeat with rst pulsed low asynchronously mid-cycle -> same state immediately.
- Lookup/bypass: src_tag=2, CDB tag2=32'hA5A5A5A5 in the same cycle -> src_ready=1 and src_data=A5A5A5A5 with ROB_BYPASS_EN; src_ready=0 that cycle without it, then 1 next cycle.
